ucsbece154a_mem_arbiter: RTL
============================

// Module: ucsbece154a_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between the multicycle core and an aux port (program loader/debug).
//  Registered request/ack handshake on each side; drives the memory for a fixed number of cycles per access.
//  Core has fixed priority; a starvation counter forces an aux grant after STARVE_LIMIT back-to-back core wins.
//  Sits between the core's memory address/write-data path and the memory macro.
// PARAMETERS
//  ADDR_W        32  address width, same for both requesters and the memory
//  DATA_W        32  read/write data width
//  MEM_LAT       2   memory access cycles per transfer (>=1); read data is valid on the last one
//  STARVE_LIMIT  4   consecutive core grants with aux pending before aux is forced (>=1)
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  reset        in   1       synchronous, active-low (0 = reset)
//  core_req_i   in   1       core access request, held until core_ack_o
//  core_we_i    in   1       1 = write, 0 = read
//  core_adr_i   in   ADDR_W  core address, stable while core_req_i=1
//  core_wd_i    in   DATA_W  core write data
//  core_rd_o    out  DATA_W  registered core read data
//  core_ack_o   out  1       1-cycle completion pulse to core
//  aux_req_i    in   1       aux access request, held until aux_ack_o
//  aux_we_i     in   1       1 = write, 0 = read
//  aux_adr_i    in   ADDR_W  aux address
//  aux_wd_i     in   DATA_W  aux write data
//  aux_rd_o     out  DATA_W  registered aux read data
//  aux_ack_o    out  1       1-cycle completion pulse to aux
//  mem_en_o     out  1       memory access enable
//  mem_we_o     out  1       memory write strobe
//  mem_adr_o    out  ADDR_W  memory address
//  mem_wd_o     out  DATA_W  memory write data
//  mem_rd_i     in   DATA_W  memory read data
//  grant_o      out  2       01 = core owns memory, 10 = aux, 00 = none
// BEHAVIOUR
//  Reset (reset=0 at posedge): state IDLE, every output 0, starve count 0, access counter 0. Overrides everything.
//  Reset mid-access: access is abandoned; no ack is issued; no mem_we_o pulse occurs after the reset edge.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: arbitrate the requests sampled this cycle; if any is granted, latch the owner into grant_o and go to ACCESS.
//   ACCESS: lasts exactly MEM_LAT cycles, using a counter 0..MEM_LAT-1.
//    mem_en_o=1; mem_adr_o/mem_wd_o are driven from the granted port's inputs.
//    mem_we_o=1 only on the last ACCESS cycle, and only if we_i=1: exactly one write strobe per write.
//    At the last ACCESS cycle edge: if the access is a read, capture mem_rd_i into the owner's rd_o. Go to RESP.
//   RESP: owner's ack_o=1 for this one cycle; mem_en_o=0; grant_o cleared at the exit edge; return to IDLE.
//    Requests are ignored in RESP.
//  Latency: request first seen in IDLE at cycle t -> ack_o high in cycle t+MEM_LAT+1.
//   Back-to-back throughput is one access per MEM_LAT+2 cycles.
//  Handshake: the requester holds req/we/adr/wd stable until it sees ack. It may re-request in the cycle after ack.
//   A req dropped mid-access is a protocol violation; the access still completes and is acked.
//  rd_o holds its value until that port's next read completes; writes and the other port's accesses leave it unchanged.
//  mem_adr_o/mem_wd_o are 0 when not in ACCESS. ack_o signals of both ports are never high together.
//  Arbitration (IDLE, both requesting): core wins unless starve count == STARVE_LIMIT, in which case aux wins.
//  Starve count ($clog2(STARVE_LIMIT+1) bits, saturating):
//   +1 when core is granted while aux_req_i=1;
//   cleared when aux is granted, or when core is granted with aux_req_i=0.
//  Single requester: granted immediately regardless of the count.
// TESTING
//  MEM_LAT=2: core read adr 0x40, mem returns 0xDEADBEEF -> mem_en 2 cycles, core_ack at t+3, core_rd_o=0xDEADBEEF, aux_rd_o unchanged.
//  Aux write adr 0x100, data 0x12345678 -> exactly one mem_we_o pulse, on the 2nd ACCESS cycle, mem_adr_o=0x100; aux_ack at t+3.
//  Both req held continuously, STARVE_LIMIT=4 -> grant sequence core,core,core,core,aux,core,...; no ack overlap.
//  Core and aux assert req in the same IDLE cycle, count 0 -> core granted; aux acked one access later (t+7).
//  Reset=0 asserted during the last ACCESS cycle of a write -> no mem_we_o, no ack, all outputs 0 next cycle, IDLE.
//  MEM_LAT=1: read -> mem_en one cycle, ack at t+2; core drops req mid-access -> still acked once.

Source files
------------

// File: rtl/ucsbece154a_mem_arbiter_if.sv
// Bundles the core, aux and memory-macro signals seen by the unified-memory arbiter.
// Latency: none, wires only; timing is set by the arbiter.
// Backpressure: req is held by each requester until its ack pulse; the memory cannot stall.
//
// Ports (signal groups):
//   core_*  core request side (req/we/adr/wd in, rd/ack out)
//   aux_*   aux loader/debug request side (same shape as core)
//   mem_*   memory macro side (en/we/adr/wd out, rd in)
//   grant_o current owner: 01 core, 10 aux, 00 none
// slave modport is the arbiter's view; master is the environment's view.
interface ucsbece154a_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req_i;
    logic              core_we_i;
    logic [ADDR_W-1:0] core_adr_i;
    logic [DATA_W-1:0] core_wd_i;
    logic [DATA_W-1:0] core_rd_o;
    logic              core_ack_o;

    logic              aux_req_i;
    logic              aux_we_i;
    logic [ADDR_W-1:0] aux_adr_i;
    logic [DATA_W-1:0] aux_wd_i;
    logic [DATA_W-1:0] aux_rd_o;
    logic              aux_ack_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_adr_o;
    logic [DATA_W-1:0] mem_wd_o;
    logic [DATA_W-1:0] mem_rd_i;

    logic [1:0]        grant_o;

    modport slave (
        input  core_req_i, core_we_i, core_adr_i, core_wd_i,
        input  aux_req_i, aux_we_i, aux_adr_i, aux_wd_i,
        input  mem_rd_i,
        output core_rd_o, core_ack_o, aux_rd_o, aux_ack_o,
        output mem_en_o, mem_we_o, mem_adr_o, mem_wd_o, grant_o
    );

    modport master (
        output core_req_i, core_we_i, core_adr_i, core_wd_i,
        output aux_req_i, aux_we_i, aux_adr_i, aux_wd_i,
        output mem_rd_i,
        input  core_rd_o, core_ack_o, aux_rd_o, aux_ack_o,
        input  mem_en_o, mem_we_o, mem_adr_o, mem_wd_o, grant_o
    );
endinterface

// File: rtl/ucsbece154a_mem_arbiter.sv
// Shares one unified memory between the core (fixed priority) and an aux port, with starvation relief for aux.
// Latency: request seen in IDLE at cycle t -> ack in cycle t+MEM_LAT+1; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until ack; the loser of arbitration simply waits in IDLE.
//
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-low reset
//   bus    arbiter view (slave modport) of the core/aux/memory signal bundle
module ucsbece154a_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    ucsbece154a_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DATA_W-1:0] core_rd_q, core_rd_d;
    logic [DATA_W-1:0] aux_rd_q, aux_rd_d;

    logic              last_acc;
    logic              own_we;
    logic              starved;
    logic [ADDR_W-1:0] adr_mux;
    logic [DATA_W-1:0] wd_mux;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= 2'b00;
            starve_q  <= '0;
            core_rd_q <= '0;
            aux_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            starve_q  <= starve_d;
            core_rd_q <= core_rd_d;
            aux_rd_q  <= aux_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        core_rd_d = core_rd_q;
        aux_rd_d  = aux_rd_q;

        bus.mem_en_o   = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_adr_o  = '0;
        bus.mem_wd_o   = '0;
        bus.core_ack_o = 1'b0;
        bus.aux_ack_o  = 1'b0;

        last_acc = (state_q == ACCESS) && (cnt_q == CW'(MEM_LAT - 1));
        own_we   = grant_q[1] ? bus.aux_we_i : bus.core_we_i;
        adr_mux  = grant_q[1] ? bus.aux_adr_i : bus.core_adr_i;
        wd_mux   = grant_q[1] ? bus.aux_wd_i : bus.core_wd_i;
        starved  = bus.aux_req_i && (starve_q == SW'(STARVE_LIMIT));

        case (state_q)
            IDLE: begin
                if (bus.core_req_i && !starved) begin
                    grant_d = 2'b01;
                    state_d = ACCESS;
                    cnt_d   = '0;
                    // Only a core win that makes aux wait counts towards starvation.
                    if (!bus.aux_req_i)
                        starve_d = '0;
                    else if (starve_q != SW'(STARVE_LIMIT))
                        starve_d = starve_q + 1'b1;
                end else if (bus.aux_req_i) begin
                    grant_d  = 2'b10;
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    starve_d = '0;
                end
            end
            ACCESS: begin
                bus.mem_en_o  = 1'b1;
                bus.mem_adr_o = adr_mux;
                bus.mem_wd_o  = wd_mux;
                // Gated by reset so a reset landing on the strobe cycle cannot commit the write.
                bus.mem_we_o  = last_acc && own_we && reset;
                if (last_acc) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    if (!own_we) begin
                        if (grant_q[1])
                            aux_rd_d = bus.mem_rd_i;
                        else
                            core_rd_d = bus.mem_rd_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                bus.core_ack_o = grant_q[0];
                bus.aux_ack_o  = grant_q[1];
                grant_d        = 2'b00;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        bus.grant_o   = grant_q;
        bus.core_rd_o = core_rd_q;
        bus.aux_rd_o  = aux_rd_q;
    end
endmodule
